// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet sink: flit field layout helpers and FSM state encoding.
package noc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Flit layout: {dest, src, seq}; dest sits above the payload, src in the payload MSBs.
  function automatic int dest_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int src_lsb(input int data_w, input int addr_w);
    return data_w - addr_w;
  endfunction

  function automatic int seq_width(input int data_w, input int addr_w);
    return data_w - addr_w;
  endfunction

endpackage

// File: rtl/noc_seq_checker.sv
// Per-source expected-sequence table; flags a flit whose dest or seq is wrong, one cycle after accept.
module noc_seq_checker #(
  parameter int AddrWidth = 3,
  parameter int SeqWidth  = 29
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_p0,
  input  logic                 dest_ok_p0,
  input  logic [AddrWidth-1:0] src_p0,
  input  logic [SeqWidth-1:0]  seq_p0,
  output logic                 err_p1
);

  localparam int Entries = 1 << AddrWidth;

  logic [SeqWidth-1:0] exp_seq [Entries];

  // Misrouted flits leave the table alone; any correctly routed flit resyncs it to seq+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) exp_seq[i] <= '0;
    end else if (vld_p0 && dest_ok_p0) begin
      exp_seq[src_p0] <= seq_p0 + 1'b1;
    end
  end

  // ---- p0 -> p1 ----
  always_ff @(posedge clk) begin
    if (vld_p0) err_p1 <= !dest_ok_p0 || (seq_p0 != exp_seq[src_p0]);
  end

endmodule

// File: rtl/noc_pkt_sink.sv
// NoC receive endpoint: checks dest/seq, counts good and bad packets, raises done at ExpectedPkts.
// Optional NOC_SINK_BACKPRESSURE_EN drives ready from a 16-bit LFSR while running.
module noc_pkt_sink
  import noc_pkg::*;
#(
  parameter int address      = 0,
  parameter int numPE        = 8,
  parameter int AddrWidth    = $clog2(numPE),
  parameter int DataWidth    = 32,
  parameter int ExpectedPkts = 100,
  parameter int CntWidth     = 32
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [DataWidth+AddrWidth-1:0] i_data,
  input  logic                           i_data_valid,
  output logic                           o_data_ready,
  output logic [CntWidth-1:0]            o_pkt_count,
  output logic [CntWidth-1:0]            o_err_count,
  output logic [AddrWidth-1:0]           o_last_src,
  output logic [CntWidth-1:0]            o_cycles,
  output logic                           o_done
);

  localparam int SeqWidth = seq_width(DataWidth, AddrWidth);
  localparam int DestLsb  = dest_lsb(DataWidth);
  localparam int SrcLsb   = src_lsb(DataWidth, AddrWidth);
  localparam logic [AddrWidth-1:0] MyAddr = AddrWidth'(address);
  localparam logic [CntWidth:0]    Target = (CntWidth+1)'(ExpectedPkts);

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t state_q, state_d;

  logic                 accept_p0;
  logic [AddrWidth-1:0] dest_p0, src_p0;
  logic [SeqWidth-1:0]  seq_p0;
  logic                 vld_p1, err_p1;
  logic [AddrWidth-1:0] src_p1;
  logic [CntWidth:0]    total_nx;

  assign dest_p0   = i_data[DestLsb +: AddrWidth];
  assign src_p0    = i_data[SrcLsb +: AddrWidth];
  assign seq_p0    = i_data[SeqWidth-1:0];
  assign accept_p0 = i_data_valid && o_data_ready;
  assign total_nx  = {1'b0, o_pkt_count} + {1'b0, o_err_count} + 1'b1;
  assign o_done    = (state_q == DONE);

`ifdef NOC_SINK_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)             lfsr_q <= 16'hACE1;
    else if (state_q == RUN)  lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  always_comb begin
    o_data_ready = 1'b0;
    unique case (state_q)
`ifdef NOC_SINK_BACKPRESSURE_EN
      RUN:     o_data_ready = lfsr_q[0];
`else
      RUN:     o_data_ready = 1'b1;
`endif
      DONE:    o_data_ready = 1'b1;
      default: o_data_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start) state_d = RUN;
      RUN:     if (vld_p1 && total_nx >= Target) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  noc_seq_checker #(
    .AddrWidth (AddrWidth),
    .SeqWidth  (SeqWidth)
  ) u_chk (
    .clk        (i_clk),
    .rst_n      (i_reset),
    .vld_p0     (accept_p0),
    .dest_ok_p0 (dest_p0 == MyAddr),
    .src_p0     (src_p0),
    .seq_p0     (seq_p0),
    .err_p1     (err_p1)
  );

  // ---- p0 -> p1 ----
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) vld_p1 <= 1'b0;
    else          vld_p1 <= accept_p0;
  end

  always_ff @(posedge i_clk) begin
    if (accept_p0) src_p1 <= src_p0;
  end

  // ---- p1 -> outputs ----
  // Anything retired after DONE is surplus traffic and lands in the error count.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_pkt_count <= '0;
      o_err_count <= '0;
      o_last_src  <= '0;
      o_cycles    <= '0;
    end else begin
      if (vld_p1) begin
        if (err_p1 || state_q == DONE) o_err_count <= sat_inc(o_err_count);
        else                           o_pkt_count <= sat_inc(o_pkt_count);
        o_last_src <= src_p1;
      end
      if (state_q == RUN) o_cycles <= sat_inc(o_cycles);
    end
  end

endmodule

// File: doc/noc_pkt_sink.md
Name: noc_pkt_sink

Overview:
- Synthesizable receive-side endpoint attached to one HNoC PE output port (o_pe_dataN / o_pe_data_validN / i_pe_data_readyN).
- Consumes packets that traffic-generating PEs inject into the NoC.
- Checks destination address and per-source sequence order, and counts good and bad packets.
- Raises done when the expected count arrives, so benches and on-chip monitors need no testbench-side counting.

Parameters:
- address, 0, this endpoint's PE index; compared with the packet destination field.
- numPE, 8, number of PEs in the NoC.
- AddrWidth, $clog2(numPE), width of address fields.
- DataWidth, 32, payload width.
- ExpectedPkts, 100, packets this sink must receive before done.
- CntWidth, 32, width of the packet, error and cycle counters.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle pulse; arms the sink (IDLE->RUN).
- i_data  in  DataWidth+AddrWidth  flit from NoC; [DataWidth+AddrWidth-1:DataWidth]=dest, [DataWidth-1:DataWidth-AddrWidth]=src, [DataWidth-AddrWidth-1:0]=seq.
- i_data_valid  in  1  flit valid.
- o_data_ready  out  1  sink can accept.
- o_pkt_count  out  CntWidth  accepted packets that passed all checks.
- o_err_count  out  CntWidth  accepted packets that failed any check.
- o_last_src  out  AddrWidth  src field of most recent accepted packet.
- o_cycles  out  CntWidth  cycles spent in RUN.
- o_done  out  1  all expected packets received.

Behaviour:
- Reset (i_reset=0, async):
  - state=IDLE; all counters, o_last_src and per-source expected-seq table cleared to 0.
  - o_data_ready=0, o_done=0.
- Handshake: accept when i_data_valid && o_data_ready at posedge i_clk. i_data is sampled only on accept. No combinational path from i_data_valid to o_data_ready.
- State IDLE:
  - o_data_ready=0.
  - i_start=1 -> RUN next cycle.
  - Flits presented in IDLE are not accepted and not counted.
- State RUN:
  - o_data_ready=1 (see Optional Feature).
  - o_cycles increments every cycle in RUN, saturating at all-ones.
- Checks, registered one cycle after accept:
  - dest != address -> error.
  - seq != exp_seq[src] -> error. exp_seq[src] resynchronises to seq+1 so one drop gives one error.
  - Otherwise exp_seq[src] <= seq+1 and o_pkt_count++.
  - Error -> o_err_count++. One packet increments exactly one of the two counters.
  - Seq width is DataWidth-AddrWidth; exp_seq wraps modulo 2^(DataWidth-AddrWidth). Wrap from all-ones to 0 is not an error.
- Latency: counters and o_last_src update 1 cycle after the accepting edge. Back-to-back accepts every cycle are supported, with a full-throughput 1-stage check pipeline.
- RUN->DONE when o_pkt_count+o_err_count reaches ExpectedPkts, counting the registered check result. o_done=1 from the same cycle the count is reached, then sticky.
- State DONE:
  - o_data_ready stays 1 to drain the NoC; no deadlock.
  - Further packets increment o_err_count only.
  - o_cycles frozen.
- i_start in RUN or DONE: ignored.
- Counters saturate at all-ones; no wrap.
- Reset mid-RUN: everything returns to the reset state immediately. An in-flight check-pipeline entry is discarded.

Optional Feature:
- Macro: NOC_SINK_BACKPRESSURE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle in RUN.
  - o_data_ready = LFSR[0] in RUN; this stresses NoC stall paths.
  - DONE keeps ready=1.
- Undefined: ready is constantly 1 in RUN; no LFSR logic is synthesized.

Decomposition:
- Shared package noc_pkg:
  - flit field offset/width localparams (dest, src, seq) as functions of DataWidth/AddrWidth.
  - state enum IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One natural sub-module: noc_seq_checker, holding the per-source exp_seq table and the mismatch compare. It returns an error flag, with one-cycle latency.
- The LFSR stays inline under the macro.

Test Plan:
- Reset then i_start, then 100 in-order flits from src 3 (dest=address=0, seq 0..99, valid every cycle) -> o_pkt_count=100, o_err_count=0, o_done=1 one cycle after the 100th accept, o_last_src=3.
- Flit with dest=5 sent to sink address 0 -> o_err_count=1, o_pkt_count unchanged, exp_seq for that src unchanged.
- Src 1 sends seq 0,1,3,4 -> exactly one error (at seq 3), o_pkt_count=3.
- ExpectedPkts reached, then 2 extra flits -> o_done stays 1, o_data_ready=1, o_err_count +2, o_cycles frozen.
- Assert i_reset=0 mid-RUN after 40 packets -> o_data_ready=0, counters 0, o_done=0 immediately. Flits presented before the next i_start are not accepted.
- With NOC_SINK_BACKPRESSURE_EN and random valid -> no flit lost or duplicated; o_pkt_count equals the sender's count; o_data_ready follows the LFSR sequence from seed 16'hACE1.
